// File: rtl/signed_accum_pkg.sv
// Shared types and helpers for the signed frame accumulator.
package signed_accum_pkg;

  typedef enum logic {
    MODE_WRAP,
    MODE_SAT
  } accum_mode_e;

  // Largest two's-complement value of a given width, low bits of a 64-bit word.
  function automatic logic [63:0] signed_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value; truncate the result to the target width.
  function automatic logic [63:0] signed_min(input int unsigned width);
    return ~signed_max(width);
  endfunction

endpackage

// File: rtl/signed_add_ovf.sv
// Combinational two's-complement adder with signed overflow detection.
module signed_add_ovf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);

  always_comb begin
    sum_o = a_i + b_i;
    // Same-sign operands whose truncated sum flips sign have left the range.
    ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/signed_accum_with_overflow.sv
// Frame accumulator: sums signed samples per frame, emits total and sticky overflow.
module signed_accum_with_overflow
  import signed_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter accum_mode_e MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_data,
  output logic             down_overflow
);

  localparam logic [63:0] SMaxWide = signed_max(WIDTH);
  localparam logic [63:0] SMinWide = signed_min(WIDTH);
  localparam logic [WIDTH-1:0] SMax = SMaxWide[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMin = SMinWide[WIDTH-1:0];

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             down_valid_q, down_valid_d;
  logic [WIDTH-1:0] down_data_q, down_data_d;
  logic             down_overflow_q, down_overflow_d;

  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] next_val;

  signed_add_ovf #(
    .WIDTH(WIDTH)
  ) u_add (
    .a_i  (acc_q),
    .b_i  (up_data),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    next_val = sum;
    // Overflow implies both operands share a sign, so the accumulator sign picks the rail.
    if (MODE == MODE_SAT && add_ovf) begin
      next_val = acc_q[WIDTH-1] ? SMin : SMax;
    end
  end

  always_comb begin
    acc_d           = acc_q;
    ovf_sticky_d    = ovf_sticky_q;
    down_valid_d    = 1'b0;
    down_data_d     = down_data_q;
    down_overflow_d = down_overflow_q;
    if (up_valid) begin
      if (up_last) begin
        down_valid_d    = 1'b1;
        down_data_d     = next_val;
        down_overflow_d = ovf_sticky_q | add_ovf;
        acc_d           = '0;
        ovf_sticky_d    = 1'b0;
      end else begin
        acc_d        = next_val;
        ovf_sticky_d = ovf_sticky_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q           <= '0;
      ovf_sticky_q    <= 1'b0;
      down_valid_q    <= 1'b0;
      down_data_q     <= '0;
      down_overflow_q <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      ovf_sticky_q    <= ovf_sticky_d;
      down_valid_q    <= down_valid_d;
      down_data_q     <= down_data_d;
      down_overflow_q <= down_overflow_d;
    end
  end

  assign down_valid    = down_valid_q;
  assign down_data     = down_data_q;
  assign down_overflow = down_overflow_q;

endmodule

// File: tb/tb_signed_accum_with_overflow.sv
// Checks wrap and saturate instances (WIDTH=4) against an integer frame model.
module tb_signed_accum_with_overflow;
  import signed_accum_pkg::*;

  logic       clk;
  logic       rst;
  logic       up_valid;
  logic [3:0] up_data;
  logic       up_last;
  logic       w_dv, s_dv;
  logic [3:0] w_dd, s_dd;
  logic       w_do, s_do;

  int checks = 0;
  int failures = 0;

  // Model state, index 0 = wrap, 1 = saturate.
  int m_acc[2];
  bit m_sticky[2];
  bit e_dv[2];
  int e_dd[2];
  bit e_do[2];

  signed_accum_with_overflow #(
    .WIDTH(4),
    .MODE (MODE_WRAP)
  ) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .up_valid     (up_valid),
    .up_data      (up_data),
    .up_last      (up_last),
    .down_valid   (w_dv),
    .down_data    (w_dd),
    .down_overflow(w_do)
  );

  signed_accum_with_overflow #(
    .WIDTH(4),
    .MODE (MODE_SAT)
  ) u_sat (
    .clk          (clk),
    .rst          (rst),
    .up_valid     (up_valid),
    .up_data      (up_data),
    .up_last      (up_last),
    .down_valid   (s_dv),
    .down_data    (s_dd),
    .down_overflow(s_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap4(input int s);
    return (((s + 8) % 16) + 16) % 16 - 8;
  endfunction

  function automatic int clamp4(input int s);
    if (s > 7) return 7;
    if (s < -8) return -8;
    return s;
  endfunction

  task automatic model_edge(input bit r, input bit v, input int d, input bit l);
    for (int m = 0; m < 2; m++) begin
      e_dv[m] = 1'b0;
      if (r) begin
        m_acc[m] = 0; m_sticky[m] = 1'b0; e_dd[m] = 0; e_do[m] = 1'b0;
      end else if (v) begin
        int  s   = m_acc[m] + d;
        bit  ovf = (s > 7) || (s < -8);
        int  nxt = (m == 0) ? wrap4(s) : clamp4(s);
        if (l) begin
          e_dv[m] = 1'b1; e_dd[m] = nxt; e_do[m] = m_sticky[m] | ovf;
          m_acc[m] = 0; m_sticky[m] = 1'b0;
        end else begin
          m_acc[m] = nxt; m_sticky[m] = m_sticky[m] | ovf;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model, compare all outputs just after the edge.
  task automatic cyc(input bit r, input bit v, input int d, input bit l);
    rst = r; up_valid = v; up_data = 4'(d); up_last = l;
    @(posedge clk);
    model_edge(r, v, d, l);
    #1;
    chk("wrap_valid", {3'b0, w_dv}, {3'b0, e_dv[0]});
    chk("wrap_data", w_dd, 4'(e_dd[0]));
    chk("wrap_ovf", {3'b0, w_do}, {3'b0, e_do[0]});
    chk("sat_valid", {3'b0, s_dv}, {3'b0, e_dv[1]});
    chk("sat_data", s_dd, 4'(e_dd[1]));
    chk("sat_ovf", {3'b0, s_do}, {3'b0, e_do[1]});
  endtask

  // Directed expectation straight from the test plan, independent of the model.
  task automatic pulse(input string tag, input bit sat, input int d, input bit o);
    chk({tag, "_valid"}, {3'b0, sat ? s_dv : w_dv}, 4'd1);
    chk({tag, "_data"}, sat ? s_dd : w_dd, 4'(d));
    chk({tag, "_ovf"}, {3'b0, sat ? s_do : w_do}, {3'b0, o});
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = 0; m_sticky[m] = 0; e_dv[m] = 0; e_dd[m] = 0; e_do[m] = 0;
    end
    rst = 1'b1; up_valid = 1'b0; up_data = 4'd0; up_last = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_data", w_dd, 4'd0);
    chk("reset_valid", {3'b0, s_dv}, 4'd0);

    cyc(0, 1, 3, 0); cyc(0, 1, 4, 1); pulse("wrap_3_4", 0, 7, 0);
    cyc(0, 0, 0, 0); chk("pulse_one_cycle", {3'b0, w_dv}, 4'd0);
    cyc(0, 1, 5, 0); cyc(0, 1, 5, 1); pulse("wrap_5_5", 0, -6, 1);
    pulse("sat_5_5", 1, 7, 1);
    cyc(0, 1, 5, 0); cyc(0, 1, 5, 0); cyc(0, 1, -3, 1); pulse("sat_recover", 1, 4, 1);
    cyc(0, 1, -8, 0); cyc(0, 1, -1, 1); pulse("sat_neg", 1, -8, 1);
    cyc(0, 1, 7, 0); cyc(0, 1, 1, 1); pulse("b2b_first", 1, 7, 1);
    cyc(0, 1, -1, 1); pulse("b2b_second", 1, -1, 0);
    cyc(0, 1, 2, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 3, 1); pulse("bubbles", 0, 5, 0);
    cyc(0, 0, 0, 0); chk("hold_data", w_dd, 4'd5);
    cyc(0, 0, 0, 0); chk("hold_data2", s_dd, 4'd5);
    cyc(0, 1, 6, 1); pulse("single", 0, 6, 0);
    cyc(0, 1, 3, 0); cyc(0, 1, 3, 0); cyc(1, 1, 4, 0);
    chk("post_rst_data", w_dd, 4'd0);
    chk("post_rst_ovf", {3'b0, s_do}, 4'd0);
    cyc(0, 1, 1, 1); pulse("after_rst", 0, 1, 0);
    pulse("after_rst_sat", 1, 1, 0);

    for (int i = 0; i < 400; i++) begin
      bit r = ($urandom_range(49) == 0);
      bit v = ($urandom_range(3) != 0);
      bit l = ($urandom_range(3) == 0);
      int d = int'($urandom_range(15)) - 8;
      cyc(r, v, d, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signed_accum_with_overflow.md
# signed_accum_with_overflow

Streaming signed accumulator that sums a frame of two's-complement samples and reports the frame total plus a sticky overflow flag. It generalises the 4-bit signed adder with overflow detection to a parametrised width, and adds a selectable wrap/saturate mode and frame-based accumulation state. It sits after any sample producer using the up_/down_ valid convention and emits one result per frame.

## Interface

- WIDTH, default 8: sample, accumulator and result width in bits, two's complement; minimum 2.
- MODE, default MODE_WRAP: MODE_WRAP truncates the sum to WIDTH bits; MODE_SAT clamps it to the representable range.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- up_valid  input  1  up_data and up_last are valid this cycle.
- up_data  input  WIDTH  signed sample.
- up_last  input  1  final sample of the current frame; only meaningful when up_valid is high.
- down_valid  output  1  one-cycle pulse: frame result is valid.
- down_data  output  WIDTH  signed frame total.
- down_overflow  output  1  at least one add in the frame overflowed.

## Operation

- State: acc (WIDTH, signed), ovf_sticky (1), plus output registers.
- up_valid low: no state change; bubbles of any length are allowed inside a frame.
- up_valid high: sum = acc + up_data.
  - Overflow on this add: both operands have the same sign bit and the sign bit of the WIDTH-bit truncated sum differs from it.
  - MODE_WRAP: next = truncated sum.
  - MODE_SAT with overflow: next = 2^(WIDTH-1)-1 if the operands are positive, or -2^(WIDTH-1) if they are negative. Without overflow: next = sum.
- Saturation is not latched. Later samples move acc normally from the clamped value.
- up_valid high and up_last low: acc <= next; ovf_sticky <= ovf_sticky | overflow.
- up_valid high and up_last high:
  - down_data <= next; down_overflow <= ovf_sticky | overflow; down_valid <= 1.
  - acc <= 0 and ovf_sticky <= 0, ready for the next frame.
- A single-sample frame returns that sample, with overflow 0.
- Every frame starts from acc = 0. There is no carry-over between frames.
- No backpressure: the block accepts a sample every cycle. The consumer must take each down_valid pulse.

## Timing

- Reset values: acc = 0, ovf_sticky = 0, down_valid = 0, down_data = 0, down_overflow = 0.
- Latency: the last sample is presented in cycle N; down_valid is high in cycle N+1 only.
- down_data and down_overflow hold their values between pulses until the next frame result.
- Back-to-back frames: up_last may be high on consecutive valid cycles. This gives consecutive down_valid pulses, each carrying its own frame's result and flag.
- Reset during a frame: the partial sum and sticky flag are discarded. A sample presented in the same cycle as rst is ignored. The first valid sample after rst deasserts starts a new frame.
- rst has priority over up_valid in the same cycle.

## Structure

- Package signed_accum_pkg holds:
  - typedef enum accum_mode_e { MODE_WRAP, MODE_SAT }; MODE is of this type.
  - Helper functions for the signed maximum and minimum of a given width.
- Sub-module signed_add_ovf (parameter WIDTH) is combinational. It computes a + b and the overflow bit, and is instantiated once. The saturation mux and all registers live in the top module.

## Test plan

All scenarios use WIDTH=4, range -8..7.
- Wrap mode, no overflow: samples 3, 4(last) -> down_valid one cycle after the last sample; down_data=7, down_overflow=0.
- Wrap mode, overflow: 5, 5(last) -> down_data=-6 (4'b1010), down_overflow=1.
- Saturate mode, with recovery:
  - 5, 5(last) -> 7, overflow 1.
  - 5, 5, -3(last) -> 4, overflow 1 (sticky).
  - -8, -1(last) -> -8, overflow 1.
- Back-to-back frames, saturate mode: 7, 1(last), -1(last) on consecutive cycles -> pulses 7/1 then -1/0. The first frame's overflow must not leak into the second.
- Bubbles and single-sample frames: 2, idle x3, 3(last) -> 5/0. Then 6(last) alone -> 6/0. down_data holds 5 during the idle cycles before the second result.
- Reset mid-frame: 3, 3, then rst for one cycle together with up_valid=1 and data 4, then 1(last) -> down_data=1, down_overflow=0. All outputs are 0 in the cycle after rst.
